// File: rtl/i2s_dac_sequencer.sv
// i2s_dac_sequencer
// Drains stereo sample words from the playback FIFO and serializes them to a
// WM8731-style DAC port in I2S format, with the FPGA as bit-clock master.
// Each FIFO word is one stereo frame: the left sample is in the upper half and
// the right sample is in the lower half. Both are shifted out MSB first, one
// BCLK after each DACLRC transition.
// A frame that finds the FIFO empty is sent as silence and sets a sticky
// underrun flag.

module i2s_dac_sequencer #(
    parameter int SAMPLE_BITS = 16,
    parameter int B           = 32,
    parameter int BCLK_DIV    = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         fifo_empty,
    input  logic [B-1:0] fifo_r_data,
    output logic         fifo_rd,
    output logic         bclk,
    output logic         daclrc,
    output logic         dacdat,
    output logic         busy,
    output logic         underrun,
    input  logic         underrun_clr
);

    // One frame carries both channels, so the bit counter spans 2*SAMPLE_BITS.
    localparam int FRAME_BITS = 2 * SAMPLE_BITS;
    localparam int BIT_W      = $clog2(FRAME_BITS);
    // Keep the divider at least one bit wide so that BCLK_DIV=1 still elaborates.
    localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] RIGHT_BIT0 = BIT_W'(SAMPLE_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BCLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state,     state_next;
    logic [DIV_W-1:0] div_cnt,   div_cnt_next;
    logic [BIT_W-1:0] bit_cnt,   bit_cnt_next;
    logic [B-1:0]     shift_reg, shift_reg_next;
    logic             bclk_next;
    logic             daclrc_next;
    logic             dacdat_next;
    logic             underrun_next;
    logic             underrun_set;

    logic             div_last;
    logic             fall_event;
    logic [BIT_W-1:0] bit_k;
    logic             frame_start;
    logic             pop;

    // Decode the BCLK falling-edge event and the bit index it advances to.
    always_comb begin
        div_last    = (div_cnt == DIV_LAST);
        fall_event  = div_last && bclk;
        bit_k       = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BIT_W'(1);
        frame_start = fall_event && (bit_k == '0);
        pop         = (state == RUN) && frame_start && enable && !fifo_empty;
    end

    // Pop is combinational so that it lines up with the cycle the word is loaded.
    // Reset masks it, so an aborted frame never consumes a FIFO word.
    assign fifo_rd = pop && !reset;

    assign busy = (state != IDLE);

    // Next-state logic: sequencing, BCLK divider, bit counter, shifter and pins.
    always_comb begin
        state_next     = state;
        div_cnt_next   = div_cnt;
        bit_cnt_next   = bit_cnt;
        shift_reg_next = shift_reg;
        bclk_next      = bclk;
        daclrc_next    = daclrc;
        dacdat_next    = dacdat;
        underrun_set   = 1'b0;

        case (state)
            IDLE: begin
                div_cnt_next   = '0;
                bit_cnt_next   = LAST_BIT;
                shift_reg_next = '0;
                bclk_next      = 1'b0;
                daclrc_next    = 1'b0;
                dacdat_next    = 1'b0;
                if (enable) begin
                    state_next = RUN;
                end
            end

            RUN: begin
                if (div_last) begin
                    div_cnt_next = '0;
                    bclk_next    = ~bclk;
                end else begin
                    div_cnt_next = div_cnt + DIV_W'(1);
                end

                if (fall_event) begin
                    bit_cnt_next = bit_k;
                    // The MSB end always holds the next bit to send. At a frame
                    // boundary, that bit is the right-channel LSB of the previous
                    // word, left there by the 31 shifts that came before.
                    dacdat_next  = shift_reg[B-1];
                    if (bit_k == '0) begin
                        daclrc_next = 1'b0;
                        if (enable) begin
                            if (!fifo_empty) begin
                                shift_reg_next = fifo_r_data;
                            end else begin
                                shift_reg_next = '0;
                                underrun_set   = 1'b1;
                            end
                        end else begin
                            state_next = STOP;
                        end
                    end else begin
                        shift_reg_next = {shift_reg[B-2:0], 1'b0};
                        daclrc_next    = (bit_k >= RIGHT_BIT0);
                    end
                end
            end

            STOP: begin
                if (div_last) begin
                    div_cnt_next = '0;
                    bclk_next    = ~bclk;
                end else begin
                    div_cnt_next = div_cnt + DIV_W'(1);
                end

                // Hold the final LSB for one full BCLK, then park everything low.
                if (fall_event) begin
                    state_next     = IDLE;
                    div_cnt_next   = '0;
                    bit_cnt_next   = LAST_BIT;
                    shift_reg_next = '0;
                    bclk_next      = 1'b0;
                    daclrc_next    = 1'b0;
                    dacdat_next    = 1'b0;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // A new underrun takes precedence over a clear in the same cycle.
        if (underrun_set) begin
            underrun_next = 1'b1;
        end else if (underrun_clr) begin
            underrun_next = 1'b0;
        end else begin
            underrun_next = underrun;
        end
    end

    // State and output registers, with a synchronous reset that takes priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= LAST_BIT;
            shift_reg <= '0;
            bclk      <= 1'b0;
            daclrc    <= 1'b0;
            dacdat    <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            state     <= state_next;
            div_cnt   <= div_cnt_next;
            bit_cnt   <= bit_cnt_next;
            shift_reg <= shift_reg_next;
            bclk      <= bclk_next;
            daclrc    <= daclrc_next;
            dacdat    <= dacdat_next;
            underrun  <= underrun_next;
        end
    end

endmodule

// File: tb/tb_i2s_dac_sequencer.sv
// Testbench for i2s_dac_sequencer.
// A BCLK_DIV=2 instance is driven through frame timing, underrun handling,
// stop and reset. A second instance with BCLK_DIV=1 runs against an always-full
// FIFO.

module tb_i2s_dac_sequencer;

    logic clk = 1'b0;

    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        underrun_clr = 1'b0;
    logic        fifo_empty;
    logic [31:0] fifo_r_data;
    logic        fifo_rd;
    logic        bclk;
    logic        daclrc;
    logic        dacdat;
    logic        busy;
    logic        underrun;

    logic        reset1 = 1'b1;
    logic        enable1 = 1'b0;
    logic        underrun_clr1 = 1'b0;
    logic        fifo_empty1 = 1'b0;
    logic [31:0] fifo_r_data1 = 32'h1234_5678;
    logic        fifo_rd1;
    logic        bclk1;
    logic        daclrc1;
    logic        dacdat1;
    logic        busy1;
    logic        underrun1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] mem [0:15];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pop_n = 0;
    int bad_pop = 0;
    int pop_cyc [0:15];
    int pop1_n = 0;
    int pop1_cyc [0:15];

    always #5 clk = ~clk;

    i2s_dac_sequencer #(.SAMPLE_BITS(16), .B(32), .BCLK_DIV(2)) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_r_data(fifo_r_data), .fifo_rd(fifo_rd), .bclk(bclk), .daclrc(daclrc),
        .dacdat(dacdat), .busy(busy), .underrun(underrun), .underrun_clr(underrun_clr)
    );

    i2s_dac_sequencer #(.SAMPLE_BITS(16), .B(32), .BCLK_DIV(1)) u_dut_div1 (
        .clk(clk), .reset(reset1), .enable(enable1), .fifo_empty(fifo_empty1),
        .fifo_r_data(fifo_r_data1), .fifo_rd(fifo_rd1), .bclk(bclk1), .daclrc(daclrc1),
        .dacdat(dacdat1), .busy(busy1), .underrun(underrun1), .underrun_clr(underrun_clr1)
    );

    // Small FIFO model: the head word is visible combinationally while non-empty.
    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_r_data = mem[rd_ptr[3:0]];

    // Cycle counter plus pop logging for both instances.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd) begin
            rd_ptr <= rd_ptr + 1;
            if (pop_n < 16) pop_cyc[pop_n] <= cyc;
            pop_n <= pop_n + 1;
            if (fifo_empty) bad_pop <= bad_pop + 1;
        end
        if (fifo_rd1) begin
            if (pop1_n < 16) pop1_cyc[pop1_n] <= cyc;
            pop1_n <= pop1_n + 1;
        end
    end

    // Last-resort guard so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic en, input logic clr);
        reset        = rst;
        enable       = en;
        underrun_clr = clr;
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr_ptr[3:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance to the negedge just after the next BCLK falling edge.
    task automatic wait_fall(output logic d, output logic l);
        logic p;
        int   n;
        logic done;
        p    = bclk;
        n    = 0;
        done = 1'b0;
        d    = 1'bx;
        l    = 1'bx;
        while (!done) begin
            @(negedge clk);
            n++;
            if (p && !bclk) begin
                d    = dacdat;
                l    = daclrc;
                done = 1'b1;
            end else if (n > 50) begin
                checks++;
                failures++;
                $display("[TB] FAIL fall_timeout observed=no_fall expected=bclk_fall");
                done = 1'b1;
            end
            p = bclk;
        end
    endtask

    initial begin
        logic        d;
        logic        l;
        logic        acc;
        logic [3:0]  nib;
        logic [31:0] exp_stream;
        int          t0;
        int          t1;

        exp_stream = {1'b0, 16'hA5A5, 15'h0787};
        $display("[TB] start");

        // Reset state.
        push(32'hA5A5_0F0F);
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick(3);
        checkOutput("rst_bclk", bclk, 0);
        checkOutput("rst_daclrc", daclrc, 0);
        checkOutput("rst_dacdat", dacdat, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_fifo_rd", fifo_rd, 0);
        checkOutput("rst_underrun", underrun, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(2);
        checkOutput("idle_bclk", bclk, 0);
        checkOutput("idle_fifo_rd", fifo_rd, 0);

        // First frame timing and bit stream.
        applyStimulus(1'b0, 1'b1, 1'b0);
        t0 = cyc;
        tick(1);
        checkOutput("run_busy", busy, 1);
        tick(1);
        checkOutput("t0p2_bclk", bclk, 0);
        tick(1);
        checkOutput("t0p3_bclk_rise", bclk, 1);
        checkOutput("t0p3_fifo_rd", fifo_rd, 0);
        tick(1);
        checkOutput("t0p4_fifo_rd", fifo_rd, 1);
        checkOutput("t0p4_bclk", bclk, 1);
        tick(1);
        checkOutput("t0p5_bclk_fall", bclk, 0);
        checkOutput("t0p5_fifo_rd", fifo_rd, 0);
        checkOutput("frame1_dat_0", dacdat, 0);
        checkOutput("frame1_lrc_0", daclrc, 0);
        for (int i = 1; i < 32; i++) begin
            wait_fall(d, l);
            checkOutput($sformatf("frame1_dat_%0d", i), d, exp_stream[31-i]);
            checkOutput($sformatf("frame1_lrc_%0d", i), l, (i >= 16) ? 1 : 0);
        end

        // Empty FIFO at the frame boundary.
        wait_fall(d, l);
        checkOutput("u1_k0_dat_prev_lsb", d, 1);
        checkOutput("u1_k0_lrc", l, 0);
        checkOutput("u1_underrun_set", underrun, 1);
        checkOutput("u1_pop_count", pop_n, 1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick(1);
        checkOutput("u1_underrun_clr", underrun, 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        acc = 1'b0;
        for (int i = 1; i < 32; i++) begin
            wait_fall(d, l);
            acc = acc | d;
        end
        checkOutput("u1_silence", acc, 0);

        // Set and clear in the same cycle: set wins.
        tick(3);
        checkOutput("u2_event_bclk", bclk, 1);
        checkOutput("u2_event_fifo_rd", fifo_rd, 0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick(1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("u2_fall", bclk, 0);
        checkOutput("u2_set_beats_clr", underrun, 1);
        checkOutput("u2_k0_dat", dacdat, 0);

        // Two words back to back.
        push(32'h8000_0001);
        push(32'hFFFF_0000);
        for (int i = 1; i < 32; i++) wait_fall(d, l);
        wait_fall(d, l);
        checkOutput("f2a_k0_dat", d, 0);
        checkOutput("f2a_pop_count", pop_n, 2);
        push(32'h0000_0003);
        wait_fall(d, l);
        checkOutput("f2a_k1_msb", d, 1);
        for (int i = 2; i < 32; i++) wait_fall(d, l);
        wait_fall(d, l);
        checkOutput("f2b_k0_prev_lsb", d, 1);
        checkOutput("f2b_pop_count", pop_n, 3);
        checkOutput("f2b_pop_gap", pop_cyc[2] - pop_cyc[1], 128);

        // Enable dropped at k=7: the frame completes, then STOP and IDLE.
        for (int i = 0; i < 32; i++) wait_fall(d, l);
        checkOutput("f3_pop_count", pop_n, 4);
        for (int i = 1; i <= 7; i++) wait_fall(d, l);
        applyStimulus(1'b0, 1'b0, 1'b0);
        push(32'hDEAD_BEEF);
        for (int i = 8; i < 32; i++) wait_fall(d, l);
        checkOutput("f3_k31_dat", d, 1);
        wait_fall(d, l);
        checkOutput("stop_k0_dat", d, 1);
        checkOutput("stop_k0_lrc", l, 0);
        checkOutput("stop_busy", busy, 1);
        checkOutput("stop_no_pop", pop_n, 4);
        tick(1);
        checkOutput("stop_hold_dat", dacdat, 1);
        checkOutput("stop_hold_busy", busy, 1);
        wait_fall(d, l);
        checkOutput("idle_after_stop_busy", busy, 0);
        checkOutput("idle_after_stop_bclk", bclk, 0);
        checkOutput("idle_after_stop_dat", dacdat, 0);
        checkOutput("idle_after_stop_lrc", daclrc, 0);
        tick(6);
        checkOutput("idle_quiet_bclk", bclk, 0);
        checkOutput("idle_quiet_pops", pop_n, 4);

        // Reset at k=20, then restart.
        applyStimulus(1'b0, 1'b1, 1'b0);
        t0 = cyc;
        tick(4);
        checkOutput("re_pop_strobe", fifo_rd, 1);
        tick(1);
        for (int i = 1; i <= 20; i++) wait_fall(d, l);
        checkOutput("k20_dat", d, 1);
        checkOutput("k20_lrc", l, 1);
        checkOutput("k20_underrun_still", underrun, 1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick(1);
        checkOutput("rst_mid_busy", busy, 0);
        checkOutput("rst_mid_bclk", bclk, 0);
        checkOutput("rst_mid_lrc", daclrc, 0);
        checkOutput("rst_mid_dat", dacdat, 0);
        checkOutput("rst_mid_fifo_rd", fifo_rd, 0);
        checkOutput("rst_mid_underrun", underrun, 0);
        push(32'h1357_2468);
        applyStimulus(1'b0, 1'b1, 1'b0);
        t0 = cyc;
        tick(3);
        checkOutput("restart_t3_fifo_rd", fifo_rd, 0);
        checkOutput("restart_t3_bclk", bclk, 1);
        tick(1);
        checkOutput("restart_t4_fifo_rd", fifo_rd, 1);
        tick(1);
        checkOutput("restart_pop_cycle", pop_cyc[5], t0 + 4);
        checkOutput("restart_k0_dat", dacdat, 0);
        for (int i = 0; i < 4; i++) begin
            wait_fall(d, l);
            nib = {nib[2:0], d};
        end
        checkOutput("restart_msb_nibble", nib, 4'h1);
        checkOutput("no_pop_on_empty", bad_pop, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // BCLK_DIV=1 instance.
        reset1 = 1'b0;
        tick(1);
        enable1 = 1'b1;
        t1 = cyc;
        tick(1);
        checkOutput("d1_lrc_start", daclrc1, 0);
        checkOutput("d1_dat_start", dacdat1, 0);
        checkOutput("d1_busy", busy1, 1);
        for (int j = 1; j <= 16; j++) begin
            checkOutput($sformatf("d1_bclk_%0d", j), bclk1, (j % 2 == 0) ? 1 : 0);
            tick(1);
        end
        tick(125);
        checkOutput("d1_pop_count", pop1_n, 3);
        checkOutput("d1_first_pop", pop1_cyc[0], t1 + 2);
        checkOutput("d1_pop_gap_a", pop1_cyc[1] - pop1_cyc[0], 64);
        checkOutput("d1_pop_gap_b", pop1_cyc[2] - pop1_cyc[1], 64);
        checkOutput("d1_underrun", underrun1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2s_dac_sequencer.md
Name: i2s_dac_sequencer

Overview:
- Drains stereo sample words from the playback `fifo` and serializes them to the WM8731 DAC port in I2S format.
- Generates BCLK, DACLRC and DACDAT, with the FPGA as master.
- Owns the FIFO read side: issues one-cycle `fifo_rd` pops at frame boundaries and substitutes silence on underrun.
- Sits between the sample FIFO and the codec pins; run control and status go to the top-level control logic.

Parameters:
- SAMPLE_BITS, 16, bits per channel sample.
- B, 32, FIFO word width. Must equal 2*SAMPLE_BITS. Left sample is `w[B-1:SAMPLE_BITS]`, right sample is `w[SAMPLE_BITS-1:0]`.
- BCLK_DIV, 4, clk cycles per BCLK half-period. Must be ≥1.

Ports:
- clk, input, 1, system clock; all logic on its rising edge.
- reset, input, 1, synchronous, active-high reset.
- enable, input, 1, run request. Sampled every cycle.
- fifo_empty, input, 1, FIFO empty flag.
- fifo_r_data, input, B, FIFO head word. Valid combinationally while `fifo_empty`=0.
- fifo_rd, output, 1, one-cycle pop strobe.
- bclk, output, 1, bit clock, registered.
- daclrc, output, 1, word select: 0=left, 1=right. Registered.
- dacdat, output, 1, serial data, MSB first. Registered.
- busy, output, 1, high whenever state≠IDLE.
- underrun, output, 1, sticky flag: a frame was sent as silence.
- underrun_clr, input, 1, clears `underrun`.

Behaviour:
- Reset (synchronous, priority over everything):
  - state=IDLE; div_cnt=0; bit_cnt=2*SAMPLE_BITS-1; shift register=0.
  - `bclk`, `daclrc`, `dacdat`, `fifo_rd`, `underrun`, `busy` all =0.
  - Reset mid-frame aborts immediately; no partial pop.
- States: IDLE, RUN, STOP.
- IDLE:
  - Outputs held at 0; div_cnt=0; bit_cnt=2N-1 (N=SAMPLE_BITS).
  - `enable`=1 → RUN next cycle.
- BCLK generation in RUN/STOP:
  - div_cnt counts 0..BCLK_DIV-1. At BCLK_DIV-1: div_cnt→0 and `bclk` toggles.
  - "Fall event" = a cycle with div_cnt=BCLK_DIV-1 and `bclk`=1.
  - BCLK period is 2*BCLK_DIV clk cycles; duty is exactly 50%.
- At each fall event, bit_cnt advances modulo 2N to k.
- `daclrc` and `dacdat` update in the fall-event cycle, so they change on the same clk edge as the BCLK falling edge. The codec samples on BCLK rising.
- Fall event with k=0, `enable`=1:
  - If `fifo_empty`=0: `fifo_rd`=1 for exactly this cycle, and shift register ← `fifo_r_data`.
  - If `fifo_empty`=1: `fifo_rd`=0, shift register ← 0, `underrun` set.
  - `dacdat` ← old shift-register LSB-end bit, i.e. the last bit of the previous right sample (0 for the first frame).
  - `daclrc`=0.
- Fall event with 1≤k≤2N-1:
  - `dacdat` ← shift-register MSB; shift left by 1.
  - `daclrc` = (k≥N).
  - This gives the I2S one-BCLK MSB delay after each LRC transition.
- Fall event with k=0, `enable`=0:
  - No pop, no load.
  - `dacdat` ← last bit of the previous frame; `daclrc`=0.
  - state→STOP.
- STOP: at the next fall event → IDLE, with `bclk`/`daclrc`/`dacdat`=0. Enable is not resampled in STOP.
- Enable deasserted mid-frame: the frame always completes. Enable pulses shorter than a frame while in RUN have no effect unless they are low at the k=0 event.
- Pops occur at most once per 2N BCLK periods. `fifo_rd` is never asserted while `fifo_empty`=1.
- `underrun`:
  - Set on the empty-load condition.
  - `underrun_clr` clears it.
  - Set wins if both occur in the same cycle.
- `busy` is combinational from state.

Test Plan:
- Reset then `enable`=1 at cycle t0, BCLK_DIV=2, FIFO holds 0xA5A5_0F0F:
  - `bclk` first rises at t0+3.
  - `fifo_rd` is high only at cycle t0+4; `bclk` falls at t0+5.
  - Over the following 32 BCLK falls, `dacdat` = 0 then 1010_0101_1010_0101, 0000_1111_0000_111.
  - `daclrc` = 0 for falls 0–15 and 1 for falls 16–31.
- Two words 0x8000_0001 and 0xFFFF_0000 queued back to back:
  - Second pop occurs exactly 64*BCLK_DIV clk cycles after the first.
  - Fall k=0 of frame 2 outputs 1, the right LSB of frame 1.
- FIFO empty at a k=0 event:
  - `fifo_rd` stays 0; `dacdat`=0 for the whole frame; `underrun`=1.
  - Asserting `underrun_clr` the cycle after sets `underrun` to 0.
  - Simultaneous set and clr leaves `underrun`=1.
- `enable` dropped at bit k=7 of a frame:
  - Frame completes; no further pop; one extra BCLK in STOP carries the final LSB.
  - Then IDLE: `busy`=0 and all pins 0.
- `reset` asserted at k=20 while running:
  - Next cycle: state IDLE, all outputs 0, `fifo_rd`=0.
  - Re-enable restarts at the frame start with the first pop at t+2*BCLK_DIV.
- BCLK_DIV=1:
  - `bclk` toggles every cycle.
  - `fifo_rd` is a single-cycle pulse every 64 cycles with a non-empty FIFO.
